// File: rtl/serial_frame_tx_1010_if.sv
`default_nettype none
// ============================================================================
// serial_frame_tx_1010_if : word handshake and serial output bundle
// Rev 1.0
// ============================================================================
interface serial_frame_tx_1010_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, busy, frame_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx_1010.sv
`default_nettype none
// ============================================================================
// serial_frame_tx_1010 : sends 1010 preamble, MSB-first word, then idle gap
// Rev 1.0
// ============================================================================
module serial_frame_tx_1010 #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    serial_frame_tx_1010_if.slave  bus
);
    localparam int MAX_A = (WIDTH > 4) ? WIDTH : 4;
    localparam int MAX_V = (GAP > MAX_A) ? GAP : MAX_A;
    localparam int CW    = $clog2(MAX_V) + 1;

    localparam logic [CW-1:0] PRE_LOAD  = CW'(3);
    localparam logic [CW-1:0] DATA_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.din_valid) begin
                    shift_d = bus.din;
                    cnt_d   = PRE_LOAD;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    cnt_d   = DATA_LOAD;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
                    // A zero-length gap returns straight to IDLE
                    if (GAP > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic dout_w, dout_valid_w, frame_done_w;

    // Preamble counts 3..0, so its low bit yields 1,0,1,0
    always_comb begin
        dout_w       = 1'b0;
        dout_valid_w = 1'b0;
        frame_done_w = 1'b0;
        unique case (state_q)
            S_PRE: begin
                dout_w       = cnt_q[0];
                dout_valid_w = 1'b1;
            end
            S_DATA: begin
                dout_w       = shift_q[WIDTH-1];
                dout_valid_w = 1'b1;
                frame_done_w = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign bus.din_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.dout       = dout_w;
    assign bus.dout_valid = dout_valid_w;
    assign bus.frame_done = frame_done_w;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx_1010.sv
`default_nettype none
// ============================================================================
// tb_serial_frame_tx_1010 : timeline model vs DUT, directed and random traffic
// Rev 1.0
// ============================================================================
module tb_serial_frame_tx_1010;
    localparam int W   = 8;
    localparam int G   = 1;
    localparam int PER = 5 + W + G;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx_1010_if #(.WIDTH(W)) ifc ();

    serial_frame_tx_1010 #(.WIDTH(W), .GAP(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_n is the cycle number within the current frame, 0 when idle
    int             cyc = 0;
    int             m_n = 0;
    logic [W-1:0]   m_word = '0;
    int             hs_cnt = 0;
    int             hs_cyc[$];
    bit             cap[$];
    int             done_cnt = 0;
    logic [2:0]     det_hist = 3'b000;
    int             det_cnt = 0;
    int             det_ok = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // {din_ready, busy, dout_valid, dout, frame_done}
    function automatic logic [4:0] model_out(input int n, input logic [W-1:0] w);
        logic v, d, f;
        if (n == 0) return 5'b10000;
        v = (n <= 4 + W);
        d = 1'b0;
        if (n <= 4)      d = (n % 2 == 1);
        else if (v)      d = w[W - 1 - (n - 5)];
        f = (n == 4 + W);
        return {1'b0, 1'b1, v, d, f};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_n == 0) begin
                if (ifc.din_valid) begin
                    m_n    <= 1;
                    m_word <= ifc.din;
                    hs_cnt <= hs_cnt + 1;
                    hs_cyc.push_back(cyc);
                end
            end else if (m_n >= 4 + W + G) begin
                m_n <= 0;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    // Detector watches only valid bits, firing on the 0 that completes 1010
    always @(negedge clk) begin
        logic [4:0] e, a;
        logic fire;
        e = model_out(m_n, m_word);
        a = {ifc.din_ready, ifc.busy, ifc.dout_valid, ifc.dout, ifc.frame_done};
        check("outputs", {27'd0, a}, {27'd0, e});
        if (ifc.frame_done) done_cnt <= done_cnt + 1;
        if (ifc.dout_valid) begin
            cap.push_back(ifc.dout);
            fire = !ifc.dout && (det_hist == 3'b101);
            if (fire) begin
                det_cnt <= det_cnt + 1;
                if (m_n == 4) det_ok <= det_ok + 1;
            end
            det_hist <= {det_hist[1:0], ifc.dout};
        end
    end

    function automatic logic [31:0] packed_cap();
        logic [31:0] v = '0;
        foreach (cap[i]) v = {v[30:0], cap[i]};
        return v;
    endfunction

    task automatic send(input logic [W-1:0] w);
        @(negedge clk);
        ifc.din       = w;
        ifc.din_valid = 1'b1;
        @(negedge clk);
        ifc.din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && m_n != 0; k++) @(negedge clk);
        if (m_n != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(negedge clk);
    endtask

    task automatic wait_hs(input int target);
        for (int k = 0; k < 100 && hs_cnt < target; k++) @(negedge clk);
        if (hs_cnt < target) begin
            n_cmp++; n_bad++;
            $display("FAIL hs_timeout: got %0d expected %0d", hs_cnt, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0, dc0, dk0;
        ifc.din       = '0;
        ifc.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ifc.din_ready}, 32'd1);
        check("reset_others", {28'd0, ifc.busy, ifc.dout, ifc.dout_valid, ifc.frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single A5 frame
        cap.delete(); d0 = done_cnt; h0 = hs_cnt;
        send(8'hA5);
        wait_idle();
        check("a5_len", cap.size(), 12);
        check("a5_stream", packed_cap(), 32'b1010_1010_0101);
        check("a5_done", done_cnt - d0, 1);
        check("a5_hs", hs_cnt - h0, 1);

        // Back-to-back FF then 00
        cap.delete(); h0 = hs_cnt;
        @(negedge clk);
        ifc.din = 8'hFF; ifc.din_valid = 1'b1;
        wait_hs(h0 + 1);
        ifc.din = 8'h00;
        wait_hs(h0 + 2);
        ifc.din_valid = 1'b0;
        wait_idle();
        check("b2b_spacing", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], PER);
        check("b2b_len", cap.size(), 24);
        check("b2b_stream", packed_cap(), 32'hAFFA00);

        // Loopback: three back-to-back FF frames
        dc0 = det_cnt; dk0 = det_ok; h0 = hs_cnt;
        @(negedge clk);
        ifc.din = 8'hFF; ifc.din_valid = 1'b1;
        wait_hs(h0 + 3);
        ifc.din_valid = 1'b0;
        wait_idle();
        check("det_count", det_cnt - dc0, 3);
        check("det_on_cycle4", det_ok - dk0, 3);

        // Inputs toggled while busy are ignored
        cap.delete(); h0 = hs_cnt;
        send(8'h81);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifc.din       = (i % 2) ? 8'h3C : 8'hC3;
            ifc.din_valid = (i % 2);
        end
        ifc.din_valid = 1'b0;
        wait_idle();
        check("busy_hs", hs_cnt - h0, 1);
        check("busy_stream", packed_cap(), 32'b1010_1000_0001);

        // Asynchronous reset mid-cycle during preamble
        send(8'hF0);
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        check("areset_ready", {31'd0, ifc.din_ready}, 32'd1);
        check("areset_others", {28'd0, ifc.busy, ifc.dout, ifc.dout_valid, ifc.frame_done}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during data bit 3 of an FF frame, then a clean 55 frame
        d0 = done_cnt;
        send(8'hFF);
        repeat (8) @(posedge clk);
        #3;
        check("pre_rst_bit3", {30'd0, ifc.dout_valid, ifc.dout}, 32'd3);
        rst_n = 1'b0; #1;
        check("mid_rst_dout", {30'd0, ifc.dout_valid, ifc.dout}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_nodone", done_cnt - d0, 0);
        cap.delete();
        send(8'h55);
        wait_idle();
        check("post_rst_stream", packed_cap(), 32'b1010_0101_0101);
        check("post_rst_done", done_cnt - d0, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            ifc.din       = W'($urandom);
            ifc.din_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        ifc.din_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
